// File: rtl/axi2apb_bus1.sv
// AXI4 to APB bridge for the Bus[1] peripheral segment (UART1, PRCI, DMI, GPIO, DDR, PnP).
// Optional PREADY watchdog enabled by defining AXI2APB_BUS1_TIMEOUT_EN.

package axi2apb_bus1_pkg;

   localparam int CFG_ADDR_BITS = 48;
   localparam int CFG_ID_BITS = 5;
   localparam int CFG_BUS1_PSLV_TOTAL = 6;

   localparam int CFG_BUS1_PSLV_UART1 = 0;
   localparam int CFG_BUS1_PSLV_PRCI = 1;
   localparam int CFG_BUS1_PSLV_DMI = 2;
   localparam int CFG_BUS1_PSLV_GPIO = 3;
   localparam int CFG_BUS1_PSLV_DDR = 4;
   localparam int CFG_BUS1_PSLV_PNP = 5;

   typedef struct packed {
      logic [CFG_ADDR_BITS-1:0] addr_start;
      logic [CFG_ADDR_BITS-1:0] addr_end;
   } mapinfo_type;

   localparam mapinfo_type CFG_BUS1_MAP [CFG_BUS1_PSLV_TOTAL] = '{
      '{48'h0000_0001_0000, 48'h0000_0001_1000},
      '{48'h0000_0001_2000, 48'h0000_0001_3000},
      '{48'h0000_0001_E000, 48'h0000_0001_F000},
      '{48'h0000_0006_0000, 48'h0000_0006_1000},
      '{48'h0000_000C_0000, 48'h0000_000C_1000},
      '{48'h0000_000F_F000, 48'h0000_0010_0000}
   };

   typedef struct packed {
      logic aw_valid;
      logic [CFG_ADDR_BITS-1:0] aw_addr;
      logic [7:0] aw_len;
      logic [2:0] aw_size;
      logic [1:0] aw_burst;
      logic [2:0] aw_prot;
      logic [CFG_ID_BITS-1:0] aw_id;
      logic aw_user;
      logic w_valid;
      logic [63:0] w_data;
      logic [7:0] w_strb;
      logic w_last;
      logic b_ready;
      logic ar_valid;
      logic [CFG_ADDR_BITS-1:0] ar_addr;
      logic [7:0] ar_len;
      logic [2:0] ar_size;
      logic [1:0] ar_burst;
      logic [2:0] ar_prot;
      logic [CFG_ID_BITS-1:0] ar_id;
      logic ar_user;
      logic r_ready;
   } axi4_slave_in_type;

   typedef struct packed {
      logic aw_ready;
      logic w_ready;
      logic b_valid;
      logic [1:0] b_resp;
      logic [CFG_ID_BITS-1:0] b_id;
      logic b_user;
      logic ar_ready;
      logic r_valid;
      logic [1:0] r_resp;
      logic [63:0] r_data;
      logic r_last;
      logic [CFG_ID_BITS-1:0] r_id;
      logic r_user;
   } axi4_slave_out_type;

   typedef struct packed {
      logic [31:0] paddr;
      logic [2:0] pprot;
      logic pselx;
      logic penable;
      logic pwrite;
      logic [31:0] pwdata;
      logic [3:0] pstrb;
   } apb_in_type;

   typedef struct packed {
      logic pready;
      logic [31:0] prdata;
      logic pslverr;
   } apb_out_type;

   typedef apb_in_type [CFG_BUS1_PSLV_TOTAL-1:0] bus1_apb_in_vector;
   typedef apb_out_type [CFG_BUS1_PSLV_TOTAL-1:0] bus1_apb_out_vector;

endpackage

module axi2apb_bus1
   import axi2apb_bus1_pkg::*;
#(
   parameter int async_reset = 0,
   parameter int CFG_TIMEOUT_CYCLES = 256
) (
   input logic i_clk,
   input logic i_rst,
   input axi4_slave_in_type i_xslvi,
   output axi4_slave_out_type o_xslvo,
   input bus1_apb_out_vector i_apbo,
   output bus1_apb_in_vector o_apbi
);

   typedef enum logic [2:0] {
      s_idle,
      s_wdata,
      s_setup,
      s_access,
      s_out
   } state_t;

   state_t state;
   state_t state_n;

   logic [CFG_ADDR_BITS-1:0] addr;
   logic [CFG_ADDR_BITS-1:0] addr_d;
   logic [CFG_ADDR_BITS-1:0] adv_addr;
   logic [7:0] len;
   logic [2:0] size;
   logic [2:0] size_d;
   logic [1:0] burst;
   logic [2:0] prot;
   logic [CFG_ID_BITS-1:0] id;
   logic user;
   logic is_write;
   logic [7:0] beat_cnt;
   logic half;
   logic [2:0] idx;
   logic dec_err;
   logic beat_err;
   logic [1:0] wresp;
   logic [63:0] wdata;
   logic [7:0] wstrb;
   logic [63:0] rdata;

   logic hit_d;
   logic [2:0] idx_d;
   logic accept_ar;
   logic accept_aw;
   logic take_w;
   logic start_beat;
   logic apb_done;
   logic next_half;
   logic advance;
   logic last;
   logic sel_pready;
   logic [1:0] beat_resp;
   logic [1:0] wresp_fin;
   logic [31:0] cap_data;
   logic cap_err;
   logic tmo_hit;
   logic unused_bits;

   assign unused_bits = ^{i_xslvi.w_last, 1'(async_reset),
                          1'(CFG_TIMEOUT_CYCLES)};

   assign last = (beat_cnt == len);
   assign sel_pready = i_apbo[idx].pready;
   assign beat_resp = dec_err ? 2'b11 : (beat_err ? 2'b10 : 2'b00);
   assign wresp_fin = (beat_resp > wresp) ? beat_resp : wresp;
   assign adv_addr = (burst == 2'b00) ? addr :
                     {addr[CFG_ADDR_BITS-1:12], addr[11:0] + (12'd1 << size)};

`ifdef AXI2APB_BUS1_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   assign tmo_hit = (state == s_access) && !sel_pready &&
                    (tmo_cnt == 32'(CFG_TIMEOUT_CYCLES - 1));

   // PREADY watchdog: counts Access cycles, cleared in every Setup
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tmo_cnt <= '0;
      end else if (state == s_setup) begin
         tmo_cnt <= '0;
      end else if (state == s_access) begin
         tmo_cnt <= tmo_cnt + 32'd1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   assign cap_data = tmo_hit ? 32'hDEAD_C0DE : i_apbo[idx].prdata;
   assign cap_err = tmo_hit | i_apbo[idx].pslverr;

   // Next address and size as they will be registered this cycle
   always_comb begin
      addr_d = addr;
      size_d = size;
      if (accept_ar) begin
         addr_d = i_xslvi.ar_addr;
         size_d = i_xslvi.ar_size;
      end else if (accept_aw) begin
         addr_d = i_xslvi.aw_addr;
         size_d = i_xslvi.aw_size;
      end else if (advance) begin
         addr_d = adv_addr;
      end
   end

   // Address decode against the Bus[1] map, full mapinfo width
   always_comb begin
      hit_d = 1'b0;
      idx_d = '0;
      for (int i = 0; i < CFG_BUS1_PSLV_TOTAL; i++) begin
         if (addr_d >= CFG_BUS1_MAP[i].addr_start &&
             addr_d < CFG_BUS1_MAP[i].addr_end) begin
            hit_d = 1'b1;
            idx_d = 3'(i);
         end
      end
   end

   // Transfer sequencing: next state and per-cycle control strobes
   always_comb begin
      state_n = state;
      accept_ar = 1'b0;
      accept_aw = 1'b0;
      take_w = 1'b0;
      start_beat = 1'b0;
      apb_done = 1'b0;
      next_half = 1'b0;
      advance = 1'b0;
      unique case (state)
         s_idle: begin
            if (i_xslvi.ar_valid) begin
               accept_ar = 1'b1;
               start_beat = 1'b1;
            end else if (i_xslvi.aw_valid) begin
               accept_aw = 1'b1;
               state_n = s_wdata;
            end
         end
         s_wdata: begin
            if (i_xslvi.w_valid) begin
               take_w = 1'b1;
               start_beat = 1'b1;
            end
         end
         s_setup: begin
            state_n = s_access;
         end
         s_access: begin
            if (sel_pready || tmo_hit) begin
               apb_done = 1'b1;
               if (size == 3'd3 && !half) begin
                  next_half = 1'b1;
                  state_n = s_setup;
               end else begin
                  state_n = s_out;
               end
            end
         end
         s_out: begin
            if (!is_write) begin
               if (i_xslvi.r_ready) begin
                  if (last) begin
                     state_n = s_idle;
                  end else begin
                     advance = 1'b1;
                     start_beat = 1'b1;
                  end
               end
            end else if (!last) begin
               advance = 1'b1;
               state_n = s_wdata;
            end else if (i_xslvi.b_ready) begin
               state_n = s_idle;
            end
         end
         default: begin
            state_n = s_idle;
         end
      endcase
      if (start_beat) begin
         state_n = hit_d ? s_setup : s_out;
      end
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= s_idle;
      end else begin
         state <= state_n;
      end
   end

   // Transaction context, beat bookkeeping and data capture
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr <= '0;
         len <= '0;
         size <= '0;
         burst <= '0;
         prot <= '0;
         id <= '0;
         user <= 1'b0;
         is_write <= 1'b0;
         beat_cnt <= '0;
         half <= 1'b0;
         idx <= '0;
         dec_err <= 1'b0;
         beat_err <= 1'b0;
         wresp <= '0;
         wdata <= '0;
         wstrb <= '0;
         rdata <= '0;
      end else begin
         addr <= addr_d;
         if (accept_ar) begin
            len <= i_xslvi.ar_len;
            size <= i_xslvi.ar_size;
            burst <= i_xslvi.ar_burst;
            prot <= i_xslvi.ar_prot;
            id <= i_xslvi.ar_id;
            user <= i_xslvi.ar_user;
            is_write <= 1'b0;
            beat_cnt <= '0;
            wresp <= '0;
         end else if (accept_aw) begin
            len <= i_xslvi.aw_len;
            size <= i_xslvi.aw_size;
            burst <= i_xslvi.aw_burst;
            prot <= i_xslvi.aw_prot;
            id <= i_xslvi.aw_id;
            user <= i_xslvi.aw_user;
            is_write <= 1'b1;
            beat_cnt <= '0;
            wresp <= '0;
         end
         if (take_w) begin
            wdata <= i_xslvi.w_data;
            wstrb <= i_xslvi.w_strb;
         end
         if (advance) begin
            beat_cnt <= beat_cnt + 8'd1;
            wresp <= wresp_fin;
         end
         if (start_beat) begin
            idx <= idx_d;
            dec_err <= !hit_d;
            beat_err <= 1'b0;
            half <= (size_d == 3'd3) ? 1'b0 : addr_d[2];
            if (!hit_d) begin
               rdata <= '0;
            end
         end
         if (next_half) begin
            half <= 1'b1;
         end
         if (apb_done) begin
            beat_err <= beat_err | cap_err;
            if (size <= 3'd2) begin
               rdata <= {cap_data, cap_data};
            end else if (half) begin
               rdata[63:32] <= cap_data;
            end else begin
               rdata[31:0] <= cap_data;
            end
         end
      end
   end

   // APB drive: only the decoded slave sees pselx, in Setup and Access
   always_comb begin
      o_apbi = '0;
      if (state == s_setup || state == s_access) begin
         o_apbi[idx].pselx = 1'b1;
         o_apbi[idx].penable = (state == s_access);
         o_apbi[idx].pwrite = is_write;
         o_apbi[idx].paddr = {addr[31:3], half, 2'b00};
         o_apbi[idx].pwdata = half ? wdata[63:32] : wdata[31:0];
         o_apbi[idx].pstrb = half ? wstrb[7:4] : wstrb[3:0];
         o_apbi[idx].pprot = prot;
      end
   end

   // AXI response and ready signalling
   always_comb begin
      o_xslvo = '0;
      o_xslvo.ar_ready = (state == s_idle) && !i_rst;
      o_xslvo.aw_ready = (state == s_idle) && !i_rst && !i_xslvi.ar_valid;
      o_xslvo.w_ready = (state == s_wdata);
      if (state == s_out && !is_write) begin
         o_xslvo.r_valid = 1'b1;
         o_xslvo.r_data = rdata;
         o_xslvo.r_resp = beat_resp;
         o_xslvo.r_last = last;
         o_xslvo.r_id = id;
         o_xslvo.r_user = user;
      end
      if (state == s_out && is_write && last) begin
         o_xslvo.b_valid = 1'b1;
         o_xslvo.b_resp = wresp_fin;
         o_xslvo.b_id = id;
         o_xslvo.b_user = user;
      end
   end

endmodule

// File: tb/tb_axi2apb_bus1.sv
// Directed self-checking bench for axi2apb_bus1.
// Covers reset, reads/writes per slave, decode miss, bursts, AR/AW arbitration, abort and watchdog.

module tb_axi2apb_bus1;
   import axi2apb_bus1_pkg::*;

   typedef struct packed {
      logic [2:0] slv;
      logic [31:0] paddr;
      logic pwrite;
      logic [31:0] pwdata;
      logic [3:0] pstrb;
   } xfer_t;

   logic clk;
   logic rst;
   axi4_slave_in_type xi;
   axi4_slave_out_type xo;
   bus1_apb_out_vector apbo;
   bus1_apb_in_vector apbi;

   int checks;
   int failures;

   logic hang;
   int wait_cfg;
   logic [31:0] prdata_cfg;
   logic [31:0] err_addr;
   int wcnt;
   int mon_err;
   int sel_cnt [6];
   xfer_t apb_q[$];

   logic [63:0] rd_data [8];
   logic [1:0] rd_resp [8];
   logic rd_last [8];
   int rd_n;
   int rd_lat;
   int rd_to;
   int wr_bcnt;
   logic [1:0] wr_bresp;
   int wr_to;

   axi2apb_bus1 #(
      .async_reset(0),
      .CFG_TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_xslvi(xi),
      .o_xslvo(xo),
      .i_apbo(apbo),
      .o_apbi(apbi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // APB slave model: shared wait count, optional error address, hang switch
   always_comb begin
      apbo = '0;
      for (int i = 0; i < 6; i++) begin
         apbo[i].pready = apbi[i].penable && !hang && (wcnt >= wait_cfg);
         apbo[i].prdata = prdata_cfg;
         apbo[i].pslverr = apbi[i].penable && (apbi[i].paddr == err_addr);
      end
   end

   // Bus monitor: wait counter, completed transfers, protocol violations
   always @(posedge clk) begin
      int npsel;
      npsel = 0;
      for (int i = 0; i < 6; i++) begin
         if (apbi[i].pselx) npsel++;
         if (apbi[i].pselx && !apbi[i].penable) sel_cnt[i] <= sel_cnt[i] + 1;
         if (apbi[i].penable && !apbi[i].pselx) mon_err <= mon_err + 1;
         if (apbi[i].penable && apbo[i].pready)
            apb_q.push_back('{3'(i), apbi[i].paddr, apbi[i].pwrite,
                              apbi[i].pwdata, apbi[i].pstrb});
      end
      if (npsel > 1) mon_err <= mon_err + 1;
      wcnt <= (npsel > 0 && (|{apbi[0].penable, apbi[1].penable, apbi[2].penable,
                                 apbi[3].penable, apbi[4].penable, apbi[5].penable}))
              ? wcnt + 1 : 0;
   end

   task automatic do_read(input logic [47:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n;
      bit done;
      rd_n = 0;
      rd_lat = 0;
      rd_to = 0;
      @(negedge clk);
      xi.ar_valid = 1'b1;
      xi.ar_addr = a;
      xi.ar_len = len;
      xi.ar_size = size;
      xi.ar_burst = burst;
      xi.ar_prot = 3'd2;
      xi.ar_id = 5'd3;
      n = 0;
      while (!xo.ar_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      xi.ar_valid = 1'b0;
      rd_lat = 1;
      n = 0;
      done = 0;
      while (!done && n < 400) begin
         if (xo.r_valid) begin
            rd_data[rd_n] = xo.r_data;
            rd_resp[rd_n] = xo.r_resp;
            rd_last[rd_n] = xo.r_last;
            rd_n++;
            if (xo.r_last || rd_n == 8) done = 1;
         end
         if (!done) begin
            @(negedge clk);
            n++;
            if (rd_n == 0) rd_lat++;
         end
      end
      if (!done) rd_to = 1;
   endtask

   task automatic do_write(input logic [47:0] a, input logic [2:0] size,
                           input logic [63:0] d, input logic [7:0] s);
      int n;
      wr_bcnt = 0;
      wr_bresp = 2'bxx;
      wr_to = 0;
      @(negedge clk);
      xi.aw_valid = 1'b1;
      xi.aw_addr = a;
      xi.aw_len = 8'd0;
      xi.aw_size = size;
      xi.aw_burst = 2'b01;
      xi.aw_prot = 3'd0;
      xi.aw_id = 5'd7;
      n = 0;
      while (!xo.aw_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      xi.aw_valid = 1'b0;
      xi.w_valid = 1'b1;
      xi.w_data = d;
      xi.w_strb = s;
      xi.w_last = 1'b1;
      n = 0;
      while (!xo.w_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      xi.w_valid = 1'b0;
      n = 0;
      while (!xo.b_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (xo.b_valid) begin
         wr_bresp = xo.b_resp;
         wr_bcnt = 1;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (xo.b_valid) wr_bcnt++;
         end
      end else begin
         wr_to = 1;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (xo !== '0) begin
         failures++;
         $display("FAIL reset_xslvo got=%h exp=0", xo);
      end
      checks++;
      if (apbi !== '0) begin
         failures++;
         $display("FAIL reset_apbi got=%h exp=0", apbi);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (xo.ar_ready !== 1'b1 || xo.aw_ready !== 1'b1) begin
         failures++;
         $display("FAIL idle_ready got=%b%b exp=11", xo.ar_ready, xo.aw_ready);
      end
   endtask

   task automatic test_uart_read();
      int qb;
      int s0;
      qb = apb_q.size();
      s0 = sel_cnt[0];
      wait_cfg = 2;
      prdata_cfg = 32'h1234_5678;
      do_read(48'h10004, 8'd0, 3'd2, 2'b01);
      checks++;
      if (rd_to !== 0 || rd_n !== 1) begin
         failures++;
         $display("FAIL uart_beats got=%0d exp=1 to=%0d", rd_n, rd_to);
      end
      checks++;
      if (apb_q.size() - qb !== 1 || sel_cnt[0] - s0 !== 1) begin
         failures++;
         $display("FAIL uart_apb_count got=%0d exp=1", apb_q.size() - qb);
      end else begin
         checks++;
         if (apb_q[qb].paddr !== 32'h10004 || apb_q[qb].slv !== 3'd0 ||
             apb_q[qb].pwrite !== 1'b0) begin
            failures++;
            $display("FAIL uart_paddr got=%h/%0d exp=00010004/0",
                     apb_q[qb].paddr, apb_q[qb].slv);
         end
      end
      checks++;
      if (rd_data[0] !== 64'h12345678_12345678 || rd_resp[0] !== 2'b00 ||
          rd_last[0] !== 1'b1) begin
         failures++;
         $display("FAIL uart_rdata got=%h/%b/%b exp=1234567812345678/00/1",
                  rd_data[0], rd_resp[0], rd_last[0]);
      end
   endtask

   task automatic test_gpio_write64();
      int qb;
      qb = apb_q.size();
      wait_cfg = 0;
      do_write(48'h60000, 3'd3, 64'hAABBCCDD_11223344, 8'hFF);
      checks++;
      if (wr_to !== 0 || wr_bcnt !== 1 || wr_bresp !== 2'b00) begin
         failures++;
         $display("FAIL gpio_b got=cnt%0d/%b exp=cnt1/00", wr_bcnt, wr_bresp);
      end
      checks++;
      if (apb_q.size() - qb !== 2) begin
         failures++;
         $display("FAIL gpio_apb_count got=%0d exp=2", apb_q.size() - qb);
      end else begin
         checks++;
         if (apb_q[qb] !== '{3'd3, 32'h60000, 1'b1, 32'h11223344, 4'hF}) begin
            failures++;
            $display("FAIL gpio_lo got=%h exp=%h", apb_q[qb],
                     xfer_t'({3'd3, 32'h60000, 1'b1, 32'h11223344, 4'hF}));
         end
         checks++;
         if (apb_q[qb+1] !== '{3'd3, 32'h60004, 1'b1, 32'hAABBCCDD, 4'hF}) begin
            failures++;
            $display("FAIL gpio_hi got=%h exp=%h", apb_q[qb+1],
                     xfer_t'({3'd3, 32'h60004, 1'b1, 32'hAABBCCDD, 4'hF}));
         end
      end
   endtask

   task automatic test_unmapped();
      int qb;
      int sa;
      qb = apb_q.size();
      sa = sel_cnt[0] + sel_cnt[1] + sel_cnt[2] + sel_cnt[3] + sel_cnt[4] + sel_cnt[5];
      prdata_cfg = 32'hFFFF_FFFF;
      do_read(48'h20000, 8'd0, 3'd2, 2'b01);
      checks++;
      if ((sel_cnt[0] + sel_cnt[1] + sel_cnt[2] + sel_cnt[3] + sel_cnt[4] + sel_cnt[5])
          - sa !== 0 || apb_q.size() !== qb) begin
         failures++;
         $display("FAIL unmapped_psel got=%0d exp=0", apb_q.size() - qb);
      end
      checks++;
      if (rd_to !== 0 || rd_resp[0] !== 2'b11 || rd_data[0] !== 64'd0 ||
          rd_last[0] !== 1'b1) begin
         failures++;
         $display("FAIL unmapped_resp got=%b/%h exp=11/0", rd_resp[0], rd_data[0]);
      end
   endtask

   task automatic test_pnp_burst();
      int qb;
      logic [1:0] exp_resp [4];
      qb = apb_q.size();
      exp_resp = '{2'b00, 2'b00, 2'b10, 2'b00};
      wait_cfg = 0;
      prdata_cfg = 32'h5A5A_0001;
      err_addr = 32'hFF008;
      do_read(48'hFF000, 8'd3, 3'd2, 2'b01);
      err_addr = 32'hFFFF_FFFF;
      checks++;
      if (rd_to !== 0 || rd_n !== 4 || apb_q.size() - qb !== 4) begin
         failures++;
         $display("FAIL pnp_beats got=%0d/%0d exp=4/4", rd_n, apb_q.size() - qb);
      end else begin
         for (int b = 0; b < 4; b++) begin
            checks++;
            if (apb_q[qb+b].paddr !== 32'hFF000 + 32'(4 * b) ||
                apb_q[qb+b].slv !== 3'd5) begin
               failures++;
               $display("FAIL pnp_paddr%0d got=%h exp=%h", b, apb_q[qb+b].paddr,
                        32'hFF000 + 32'(4 * b));
            end
            checks++;
            if (rd_resp[b] !== exp_resp[b] || rd_last[b] !== (b == 3) ||
                rd_data[b] !== 64'h5A5A0001_5A5A0001) begin
               failures++;
               $display("FAIL pnp_beat%0d got=%b/%b/%h exp=%b/%b/5a5a00015a5a0001",
                        b, rd_resp[b], rd_last[b], rd_data[b], exp_resp[b], b == 3);
            end
         end
      end
   endtask

   task automatic test_latency();
      int qb;
      wait_cfg = 0;
      prdata_cfg = 32'h0000_BEEF;
      do_read(48'h12000, 8'd0, 3'd2, 2'b01);
      checks++;
      if (rd_to !== 0 || rd_lat !== 3) begin
         failures++;
         $display("FAIL lat32 got=%0d exp=3", rd_lat);
      end
      qb = apb_q.size();
      do_read(48'h12000, 8'd0, 3'd3, 2'b01);
      checks++;
      if (rd_to !== 0 || rd_lat !== 5) begin
         failures++;
         $display("FAIL lat64 got=%0d exp=5", rd_lat);
      end
      checks++;
      if (apb_q.size() - qb !== 2 || apb_q[qb].paddr !== 32'h12000 ||
          apb_q[qb+1].paddr !== 32'h12004 || rd_data[0] !== 64'h0000BEEF_0000BEEF) begin
         failures++;
         $display("FAIL lat64_xfers got=%0d/%h exp=2/0000beef0000beef",
                  apb_q.size() - qb, rd_data[0]);
      end
   endtask

   task automatic test_back_to_back();
      int qb;
      int n;
      bit early_aw;
      bit got_r;
      qb = apb_q.size();
      early_aw = 0;
      got_r = 0;
      wait_cfg = 1;
      prdata_cfg = 32'h0000_1111;
      @(negedge clk);
      xi.ar_valid = 1'b1;
      xi.ar_addr = 48'h12000;
      xi.ar_len = 8'd0;
      xi.ar_size = 3'd2;
      xi.ar_burst = 2'b01;
      xi.aw_valid = 1'b1;
      xi.aw_addr = 48'hC0000;
      xi.aw_len = 8'd0;
      xi.aw_size = 3'd2;
      xi.aw_burst = 2'b01;
      #1;
      checks++;
      if (xo.ar_ready !== 1'b1 || xo.aw_ready !== 1'b0) begin
         failures++;
         $display("FAIL collide_ready got=%b%b exp=10", xo.ar_ready, xo.aw_ready);
      end
      @(negedge clk);
      xi.ar_valid = 1'b0;
      n = 0;
      while (!xo.r_valid && n < 100) begin
         if (xo.aw_ready) early_aw = 1;
         @(negedge clk);
         n++;
      end
      got_r = xo.r_valid;
      checks++;
      if (got_r !== 1'b1 || early_aw !== 1'b0 || xo.r_data !== 64'h00001111_00001111) begin
         failures++;
         $display("FAIL collide_read got=r%b/aw%b/%h exp=r1/aw0/0000111100001111",
                  got_r, early_aw, xo.r_data);
      end
      n = 0;
      @(negedge clk);
      while (!xo.aw_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      xi.aw_valid = 1'b0;
      xi.w_valid = 1'b1;
      xi.w_data = 64'h0000_0000_CAFE_F00D;
      xi.w_strb = 8'h0F;
      @(negedge clk);
      xi.w_valid = 1'b0;
      n = 0;
      while (!xo.b_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (xo.b_valid !== 1'b1 || xo.b_resp !== 2'b00) begin
         failures++;
         $display("FAIL collide_b got=%b/%b exp=1/00", xo.b_valid, xo.b_resp);
      end
      @(negedge clk);
      checks++;
      if (apb_q.size() - qb !== 2) begin
         failures++;
         $display("FAIL collide_count got=%0d exp=2", apb_q.size() - qb);
      end else begin
         checks++;
         if (apb_q[qb].slv !== 3'd1 || apb_q[qb].pwrite !== 1'b0 ||
             apb_q[qb+1] !== '{3'd4, 32'hC0000, 1'b1, 32'hCAFEF00D, 4'hF}) begin
            failures++;
            $display("FAIL collide_order got=%h,%h exp=prci-rd,ddr-wr",
                     apb_q[qb], apb_q[qb+1]);
         end
      end
      checks++;
      if (mon_err !== 0) begin
         failures++;
         $display("FAIL apb_protocol got=%0d exp=0", mon_err);
      end
   endtask

   task automatic test_reset_abort();
      int n;
      int rv;
      hang = 1'b1;
      wait_cfg = 0;
      @(negedge clk);
      xi.ar_valid = 1'b1;
      xi.ar_addr = 48'h1E000;
      xi.ar_len = 8'd0;
      xi.ar_size = 3'd2;
      xi.ar_burst = 2'b01;
      @(negedge clk);
      xi.ar_valid = 1'b0;
      n = 0;
      while (!apbi[2].penable && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (apbi[2].penable !== 1'b1 || apbi[2].pselx !== 1'b1) begin
         failures++;
         $display("FAIL abort_access got=%b exp=1", apbi[2].penable);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (apbi !== '0 || xo !== '0) begin
         failures++;
         $display("FAIL abort_async got=%h/%h exp=0/0", apbi, xo);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      hang = 1'b0;
      rv = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (xo.r_valid) rv++;
      end
      checks++;
      if (rv !== 0 || xo.ar_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_idle got=rv%0d/ar%b exp=rv0/ar1", rv, xo.ar_ready);
      end
   endtask

`ifdef AXI2APB_BUS1_TIMEOUT_EN
   task automatic test_timeout();
      int qb;
      qb = apb_q.size();
      hang = 1'b1;
      do_read(48'h1E000, 8'd0, 3'd2, 2'b01);
      hang = 1'b0;
      checks++;
      if (rd_to !== 0 || rd_resp[0] !== 2'b10 || rd_data[0] !== 64'hDEADC0DE_DEADC0DE) begin
         failures++;
         $display("FAIL timeout_resp got=%b/%h exp=10/deadc0dedeadc0de",
                  rd_resp[0], rd_data[0]);
      end
      checks++;
      if (rd_lat !== 18 || apb_q.size() !== qb) begin
         failures++;
         $display("FAIL timeout_lat got=%0d exp=18", rd_lat);
      end
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      mon_err = 0;
      wcnt = 0;
      for (int i = 0; i < 6; i++) sel_cnt[i] = 0;
      hang = 1'b0;
      wait_cfg = 0;
      prdata_cfg = 32'd0;
      err_addr = 32'hFFFF_FFFF;
      xi = '0;
      xi.r_ready = 1'b1;
      xi.b_ready = 1'b1;
      rst = 1'b1;
      test_reset();
      test_uart_read();
      test_gpio_write64();
      test_unmapped();
      test_pnp_burst();
      test_latency();
      test_back_to_back();
`ifdef AXI2APB_BUS1_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
